fp_norm_pipe: RTL and testbench
===============================

# fp_norm_pipe

Pipelined, parametrised post-add/sub normaliser for the FP_AddSub datapath. It takes the raw adder mantissa with its carry bit, plus the tentative exponent. It produces a normalised mantissa and adjusted exponent with zero, denormal and overflow flags. A valid/ready handshake and a sideband tag flow alongside the data. It sits between the mantissa adder and the rounding stage, and replaces the single-cycle priority-chain normaliser.

## Interface
- EXP_WIDTH, 11: biased exponent width; exponent ports carry one extra headroom bit.
- MANT_WIDTH, 52: stored fraction width; mantissa ports are MANT_WIDTH+3 bits: [M+2] carry, [M+1] hidden, [M:1] fraction, [0] guard/sticky (M = MANT_WIDTH).
- TAG_WIDTH, 4: opaque sideband width, passed through unchanged.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_Valid  in  1  input beat valid.
- in_Ready  out  1  block can accept a beat this cycle.
- in_Exp  in  EXP_WIDTH+1  tentative biased exponent.
- in_Mant  in  MANT_WIDTH+3  raw adder mantissa.
- in_Tag  in  TAG_WIDTH  sideband.
- out_Valid  out  1  output beat valid.
- out_Ready  in  1  downstream accepts.
- out_Exp  out  EXP_WIDTH+1  normalised exponent.
- out_Mant  out  MANT_WIDTH+3  normalised mantissa.
- out_Tag  out  TAG_WIDTH  sideband, aligned with its data.
- out_Zero, out_Denorm, out_Ovf  out  1 each  result flags.

## Operation
- Pipeline advance enable: `en = !out_Valid || out_Ready`. `in_Ready = en`. A beat transfers on `in_Valid && in_Ready`.
- Global stall: when `en` is low, all three stages hold. Bubbles are not squeezed out.
- Stage 1 registers the inputs and computes the leading-zero count `lz`. `lz` counts zeros of in_Mant[M+1:0] from the hidden position, in the range 0..M+2, using a log2-tree counter. It also registers the carry bit and a zero flag.
- Stage 2 selects the action and the shift amount:
  - zero: mantissa == 0.
  - right: carry bit set.
  - none: hidden bit set.
  - left: otherwise. If `in_Exp > lz`, shift by `lz` and set `exp = in_Exp - lz`. If `in_Exp <= lz`, shift by `max(in_Exp-1, 0)`, set `exp = 0` and Denorm = 1.
  - right then overflow check: if `in_Exp + 1 >= 2^EXP_WIDTH - 1`, set Ovf = 1.
- Stage 3 performs a log2-stage barrel shift and registers the outputs:
  - right: `mant = (in >> 1) | in[0]`, so the shifted-out bit is ORed into bit 0 (sticky). `exp = in_Exp + 1`.
  - none: pass through unchanged.
  - zero: out_Mant = 0, out_Exp = 0, Zero = 1, other flags 0.
  - Ovf: out_Exp = 2^EXP_WIDTH - 1, out_Mant = 0, Denorm = 0.
- Flag rules: Zero, Denorm and Ovf are mutually exclusive. Priority is zero > right/ovf > none > left.
- All arithmetic is unsigned at EXP_WIDTH+1 bits; no wrap-around is permitted. Exponent subtraction is clamped as described above.
- out_Tag is the in_Tag of the same beat.

## Timing
- Latency is exactly 3 cycles from the accepting edge to out_Valid high with no stall. Throughput is 1 beat per cycle.
- Every stall cycle adds one cycle to the latency of each beat in flight.
- Reset (asserted at any time, including mid-stream): all stage valids = 0, out_Valid = 0, out_Exp = 0, out_Mant = 0, out_Tag = 0, all flags = 0. In-flight beats are discarded.
- After reset release, in_Ready = 1 on the first edge.
- Outputs are held stable while `out_Valid && !out_Ready`.
- in_Ready is combinational from out_Valid and out_Ready only, with no path from in_Valid.
- Simultaneous accept and emit in the same cycle is legal and loses no beat.

## Test plan
All scenarios use EXP_WIDTH=8, MANT_WIDTH=23 (26-bit mantissa: carry bit 25, hidden bit 24).

- Pass-through: exp=100, mant=26'h1000000, tag=3 -> 3 cycles later: exp=100, mant=26'h1000000, tag=3, flags 0.
- Left shift: exp=100, mant=26'h0000100 (lz=16) -> exp=84, mant=26'h1000000.
- Carry with sticky: exp=100, mant=26'h3000001 -> exp=101, mant=26'h1800001.
- Overflow: exp=254, mant=26'h2000000 -> exp=255, mant=0, Ovf=1.
- Underflow to denormal: exp=5, mant=26'h0000100 -> shift 4, mant=26'h0001000, exp=0, Denorm=1.
- Zero, stream and reset:
  - mant=0, exp=77 -> exp=0, Zero=1.
  - Stream 6 beats back-to-back with out_Ready low for cycles 4-8 -> exactly 3 beats accepted before in_Ready drops. All 6 later emerge in order with their tags.
  - Assert rst_n low mid-stream -> out_Valid=0 immediately, nothing emitted afterwards.

Source files
------------

// File: rtl/fp_norm_pipe.sv
// rtl/fp_norm_pipe.sv - three-stage post-add/sub mantissa normaliser with valid/ready and tag sideband
module fp_norm_pipe #(
  parameter int EXP_WIDTH  = 11,
  parameter int MANT_WIDTH = 52,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_Valid,
  output logic                  in_Ready,
  input  logic [EXP_WIDTH:0]    in_Exp,
  input  logic [MANT_WIDTH+2:0] in_Mant,
  input  logic [TAG_WIDTH-1:0]  in_Tag,
  output logic                  out_Valid,
  input  logic                  out_Ready,
  output logic [EXP_WIDTH:0]    out_Exp,
  output logic [MANT_WIDTH+2:0] out_Mant,
  output logic [TAG_WIDTH-1:0]  out_Tag,
  output logic                  out_Zero,
  output logic                  out_Denorm,
  output logic                  out_Ovf
);

  localparam int EW = EXP_WIDTH + 1;
  localparam int MW = MANT_WIDTH + 3;
  localparam int LZ_IN = MANT_WIDTH + 2;
  localparam int PW = 1 << $clog2(LZ_IN);
  localparam int CW = $clog2(PW) + 1;
  localparam int XW = (EW > CW) ? EW : CW;
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_WIDTH) - 1);

  typedef enum logic [1:0] {ACT_NONE, ACT_RIGHT, ACT_LEFT, ACT_ZERO} act_e;

  logic en;
  logic out_valid_q;
  assign en       = !out_valid_q || out_Ready;
  assign in_Ready = en;

  // Stage 1: leading-zero count below the carry, padded with ones so the tree never over-counts
  logic [PW-1:0] lz_vec;
  logic [CW-1:0] lz_cnt, lz_d;
  always_comb begin
    lz_vec = (PW'(in_Mant[MANT_WIDTH+1:0]) << (PW - LZ_IN)) | ((PW'(1) << (PW - LZ_IN)) - PW'(1));
    lz_cnt = '0;
    for (int k = CW - 2; k >= 0; k--) begin
      if ((lz_vec >> (PW - (1 << k))) == '0) begin
        lz_cnt[k] = 1'b1;
        lz_vec    = lz_vec << (1 << k);
      end
    end
    lz_d = (in_Mant[MANT_WIDTH+1:0] == '0) ? CW'(LZ_IN) : lz_cnt;
  end

  logic                 s1_valid_q, s1_zero_q;
  logic [EW-1:0]        s1_exp_q;
  logic [MW-1:0]        s1_mant_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;
  logic [CW-1:0]        s1_lz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_tag_q   <= '0;
      s1_lz_q    <= '0;
    end else if (en) begin
      s1_valid_q <= in_Valid;
      s1_zero_q  <= (in_Mant == '0);
      s1_exp_q   <= in_Exp;
      s1_mant_q  <= in_Mant;
      s1_tag_q   <= in_Tag;
      s1_lz_q    <= lz_d;
    end
  end

  // Stage 2: action select; left shifts are clamped so the exponent bottoms out at zero
  act_e          s2_act_d, s2_act_q;
  logic [EW-1:0] s2_exp_d, s2_exp_q;
  logic [CW-1:0] s2_sh_d, s2_sh_q;
  logic          s2_den_d, s2_den_q, s2_ovf_d, s2_ovf_q;
  logic [XW-1:0] exp_x, lz_x;

  always_comb begin
    s2_act_d = ACT_LEFT;
    s2_exp_d = s1_exp_q;
    s2_sh_d  = '0;
    s2_den_d = 1'b0;
    s2_ovf_d = 1'b0;
    exp_x    = XW'(s1_exp_q);
    lz_x     = XW'(s1_lz_q);
    if (s1_zero_q) begin
      s2_act_d = ACT_ZERO;
      s2_exp_d = '0;
    end else if (s1_mant_q[MW-1]) begin
      s2_act_d = ACT_RIGHT;
      if (({1'b0, s1_exp_q} + 1'b1) >= {1'b0, EXP_MAX}) begin
        s2_ovf_d = 1'b1;
        s2_exp_d = EXP_MAX;
      end else begin
        s2_exp_d = s1_exp_q + 1'b1;
      end
    end else if (s1_mant_q[MW-2]) begin
      s2_act_d = ACT_NONE;
    end else if (exp_x > lz_x) begin
      s2_sh_d  = s1_lz_q;
      s2_exp_d = EW'(exp_x - lz_x);
    end else begin
      s2_sh_d  = (s1_exp_q == '0) ? '0 : CW'(exp_x - XW'(1));
      s2_exp_d = '0;
      s2_den_d = 1'b1;
    end
  end

  logic                 s2_valid_q;
  logic [MW-1:0]        s2_mant_q;
  logic [TAG_WIDTH-1:0] s2_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_act_q   <= ACT_NONE;
      s2_exp_q   <= '0;
      s2_sh_q    <= '0;
      s2_den_q   <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_mant_q  <= '0;
      s2_tag_q   <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_act_q   <= s2_act_d;
      s2_exp_q   <= s2_exp_d;
      s2_sh_q    <= s2_sh_d;
      s2_den_q   <= s2_den_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_mant_q  <= s1_mant_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

  // Stage 3: log2 barrel shift and final result muxing
  logic [MW-1:0] sh_mant, out_mant_d, out_mant_q;
  logic [EW-1:0] out_exp_d, out_exp_q;
  logic          out_zero_d, out_zero_q, out_den_d, out_den_q, out_ovf_d, out_ovf_q;
  logic [TAG_WIDTH-1:0] out_tag_q;

  always_comb begin
    sh_mant = s2_mant_q;
    for (int k = 0; k < CW; k++) begin
      if (s2_sh_q[k]) sh_mant = sh_mant << (1 << k);
    end
    out_mant_d = s2_mant_q;
    out_exp_d  = s2_exp_q;
    out_zero_d = 1'b0;
    out_den_d  = 1'b0;
    out_ovf_d  = 1'b0;
    case (s2_act_q)
      ACT_ZERO: begin
        out_mant_d = '0;
        out_exp_d  = '0;
        out_zero_d = 1'b1;
      end
      ACT_RIGHT: begin
        if (s2_ovf_q) begin
          out_mant_d = '0;
          out_ovf_d  = 1'b1;
        end else begin
          out_mant_d = (s2_mant_q >> 1) | MW'(s2_mant_q[0]);
        end
      end
      ACT_LEFT: begin
        out_mant_d = sh_mant;
        out_den_d  = s2_den_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_tag_q   <= '0;
      out_zero_q  <= 1'b0;
      out_den_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= s2_valid_q;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_tag_q   <= s2_tag_q;
      out_zero_q  <= out_zero_d;
      out_den_q   <= out_den_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_Valid  = out_valid_q;
  assign out_Exp    = out_exp_q;
  assign out_Mant   = out_mant_q;
  assign out_Tag    = out_tag_q;
  assign out_Zero   = out_zero_q;
  assign out_Denorm = out_den_q;
  assign out_Ovf    = out_ovf_q;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// tb/tb_fp_norm_pipe.sv - scoreboard bench for fp_norm_pipe with EXP_WIDTH=8, MANT_WIDTH=23
module tb_fp_norm_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_Valid, in_Ready, out_Valid, out_Ready;
  logic [8:0]  in_Exp, out_Exp;
  logic [25:0] in_Mant, out_Mant;
  logic [3:0]  in_Tag, out_Tag;
  logic        out_Zero, out_Denorm, out_Ovf;

  fp_norm_pipe #(.EXP_WIDTH(8), .MANT_WIDTH(23), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_Valid(in_Valid), .in_Ready(in_Ready),
    .in_Exp(in_Exp), .in_Mant(in_Mant), .in_Tag(in_Tag),
    .out_Valid(out_Valid), .out_Ready(out_Ready),
    .out_Exp(out_Exp), .out_Mant(out_Mant), .out_Tag(out_Tag),
    .out_Zero(out_Zero), .out_Denorm(out_Denorm), .out_Ovf(out_Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  e;
    logic [25:0] m;
    logic [3:0]  t;
    logic        z, d, o;
  } beat_t;

  beat_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int acc_at_stall = -1;
  bit track_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor samples late in the low phase, after the driver has settled its inputs
  initial begin
    beat_t x;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_Valid && out_Ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got tag=%0d exp=%0d mant=%h, expected no beat", out_Tag, out_Exp, out_Mant);
        end else begin
          x = sb.pop_front();
          if (out_Exp !== x.e || out_Mant !== x.m || out_Tag !== x.t ||
              out_Zero !== x.z || out_Denorm !== x.d || out_Ovf !== x.o) begin
            n_err++;
            $display("FAIL beat_tag%0d: got exp=%0d mant=%h tag=%0d zdo=%b%b%b expected exp=%0d mant=%h tag=%0d zdo=%b%b%b",
                     x.t, out_Exp, out_Mant, out_Tag, out_Zero, out_Denorm, out_Ovf,
                     x.e, x.m, x.t, x.z, x.d, x.o);
          end
        end
      end
    end
  end

  task automatic send(input logic [8:0] ie, input logic [25:0] im, input logic [3:0] it,
                      input logic [8:0] xe, input logic [25:0] xm,
                      input logic xz, input logic xd, input logic xo);
    int w;
    beat_t b;
    @(negedge clk);
    in_Valid = 1'b1;
    in_Exp   = ie;
    in_Mant  = im;
    in_Tag   = it;
    w = 0;
    forever begin
      #4;
      if (in_Ready) begin
        b.e = xe; b.m = xm; b.t = it; b.z = xz; b.d = xd; b.o = xo;
        sb.push_back(b);
        n_acc++;
        break;
      end
      if (track_stall && acc_at_stall < 0) acc_at_stall = n_acc;
      w++;
      if (w > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: tag %0d not accepted in 50 cycles, expected acceptance", it);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_Valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    #4;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_Valid  = 1'b0;
    in_Exp    = '0;
    in_Mant   = '0;
    in_Tag    = '0;
    out_Ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {out_Valid, out_Exp, out_Mant, out_Tag, out_Zero, out_Denorm, out_Ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 64'(in_Ready), 64'd1);

    send(9'd100, 26'h1000000, 4'd3, 9'd100, 26'h1000000, 1'b0, 1'b0, 1'b0);
    send(9'd100, 26'h0000100, 4'd1, 9'd84,  26'h1000000, 1'b0, 1'b0, 1'b0);
    send(9'd100, 26'h3000001, 4'd2, 9'd101, 26'h1800001, 1'b0, 1'b0, 1'b0);
    send(9'd254, 26'h2000000, 4'd4, 9'd255, 26'h0000000, 1'b0, 1'b0, 1'b1);
    send(9'd5,   26'h0000100, 4'd5, 9'd0,   26'h0001000, 1'b0, 1'b1, 1'b0);
    send(9'd77,  26'h0000000, 4'd6, 9'd0,   26'h0000000, 1'b1, 1'b0, 1'b0);
    send(9'd16,  26'h0000100, 4'd7, 9'd0,   26'h0800000, 1'b0, 1'b1, 1'b0);
    send(9'd17,  26'h0000100, 4'd8, 9'd1,   26'h1000000, 1'b0, 1'b0, 1'b0);
    send(9'd0,   26'h0000001, 4'd9, 9'd0,   26'h0000001, 1'b0, 1'b1, 1'b0);
    send(9'd253, 26'h2000002, 4'd10, 9'd254, 26'h1000001, 1'b0, 1'b0, 1'b0);
    send(9'd1,   26'h0FFFFFF, 4'd11, 9'd0,  26'h0FFFFFF, 1'b0, 1'b1, 1'b0);
    send(9'd10,  26'h2000003, 4'd12, 9'd11, 26'h1000001, 1'b0, 1'b0, 1'b0);
    idle();
    drain();

    // Six back-to-back beats; downstream stalls during cycles 4..8
    n_acc = 0;
    acc_at_stall = -1;
    track_stall = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(9'(50 + i), 26'h1000000 + 26'(i), 4'(8 + i), 9'(50 + i), 26'h1000000 + 26'(i), 1'b0, 1'b0, 1'b0);
        idle();
      end
      begin
        for (int c = 1; c <= 20; c++) begin
          @(negedge clk);
          out_Ready = !(c >= 4 && c <= 8);
        end
      end
    join
    track_stall = 1'b0;
    chk("accepted_before_stall", 64'(acc_at_stall), 64'd3);
    drain();

    // Reset while the pipeline is full and stalled
    @(negedge clk);
    out_Ready = 1'b0;
    send(9'd30, 26'h1000000, 4'd1, 9'd30, 26'h1000000, 1'b0, 1'b0, 1'b0);
    send(9'd31, 26'h1000000, 4'd2, 9'd31, 26'h1000000, 1'b0, 1'b0, 1'b0);
    send(9'd32, 26'h1000000, 4'd3, 9'd32, 26'h1000000, 1'b0, 1'b0, 1'b0);
    idle();
    #1;
    chk("full_before_reset", 64'(out_Valid), 64'd1);
    chk("held_tag_before_reset", 64'(out_Tag), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("valid_in_reset", 64'(out_Valid), 64'd0);
    chk("data_in_reset", {out_Exp, out_Mant, out_Tag, out_Zero, out_Denorm, out_Ovf}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_Ready = 1'b1;
    #1;
    chk("ready_after_midreset", 64'(in_Ready), 64'd1);
    repeat (10) @(negedge clk);
    #4;
    chk("no_valid_after_reset", 64'(out_Valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
